i2c_byte_master: RTL and testbench

Byte-level I2C controller engine that owns the SCL/SDA open-drain pins and executes one bus primitive per command: START (or repeated START), WRITE byte, READ byte, STOP. It derives its own quarter-bit timing from `sys_clk` with a tick counter rather than a divided clock, so all logic stays in the `sys_clk` domain. It sits between the sensor-register sequencer and the pads, and is the consumer of the 400 kHz bus timing for the thermal sensor.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_quarter_tick.sv | 43 ++++
 rtl/i2c_byte_master.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte master: command codes, FSM states and
// the default quarter-bit divider.
package i2c_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 32'd31;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Data and ACK slots pull SCL low during the first two quarters.
  function automatic logic slot_scl_low(input logic [1:0] phase);
    return (phase == 2'd0) || (phase == 2'd1);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timer: counts 0..CLK_DIV in the sys_clk domain and flags the
// last cycle of each quarter phase. Held at zero while SCL is being stretched.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic hold,
  output logic phase_end
);

  localparam int unsigned CW = (CLK_DIV > 32'd0) ? $clog2(CLK_DIV + 32'd1) : 32'd1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !en || hold) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign phase_end = en && !clear && !hold && (cnt_q == CNT_MAX);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master engine: executes START / WRITE / READ / STOP on
// open-drain SCL/SDA, one primitive per accepted command.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_nack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_received,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] cmd_q, cmd_d;
  logic       nack_q, nack_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       ack_q, ack_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       busy_q, busy_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;

  logic tick_en, tick_clear, tick_hold, phase_end;

  assign tick_en = (state_q == ST_START) || (state_q == ST_BIT) ||
                   (state_q == ST_ACK)   || (state_q == ST_STOP);
  // A target stretching SCL keeps the line low although we released it.
  assign tick_hold = tick_en && !scl_oe_q && !scl_i;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .en        (tick_en),
    .clear     (tick_clear),
    .hold      (tick_hold),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    nack_d      = nack_q;
    rd_data_d   = rd_data_q;
    ack_d       = ack_q;
    rsp_valid_d = 1'b0;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;
    tick_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d      = cmd;
          nack_d     = rd_nack;
          tick_clear = 1'b1;
          phase_d    = 2'd0;
          bit_cnt_d  = 4'd0;
          case (cmd)
            CMD_START: begin
              state_d = ST_START;
              // Bus idle (SCL already high): no need to pull SCL low first.
              phase_d = scl_i ? 2'd1 : 2'd0;
            end
            CMD_WRITE: begin
              state_d = ST_BIT;
              shift_d = wr_data;
            end
            CMD_READ: begin
              state_d = ST_BIT;
              shift_d = 8'h00;
            end
            CMD_STOP: state_d = ST_STOP;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_STOP: begin
        if (phase_end) begin
          if (phase_q == 2'd3) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          phase_d = phase_q;
        end
      end
      ST_BIT: begin
        if (phase_end) begin
          if (phase_q == 2'd3) begin
            // Shift in on every slot: read data lands here, write data falls off the top.
            shift_d = {shift_q[6:0], sda_i};
            phase_d = 2'd0;
            if (bit_cnt_q == 4'd7) begin
              state_d   = ST_ACK;
              bit_cnt_d = 4'd8;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          phase_d = phase_q;
        end
      end
      ST_ACK: begin
        if (phase_end) begin
          if (phase_q == 2'd3) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            if (cmd_q == CMD_WRITE) begin
              ack_d = ~sda_i;
            end else begin
              rd_data_d = shift_q;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          phase_d = phase_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pad drive is decoded from the next state so the pins are registered.
    case (state_d)
      ST_START: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = (phase_d == 2'd2) || (phase_d == 2'd3);
      end
      ST_BIT: begin
        scl_oe_d = slot_scl_low(phase_d);
        sda_oe_d = (cmd_d == CMD_WRITE) ? ~shift_d[7] : 1'b0;
      end
      ST_ACK: begin
        scl_oe_d = slot_scl_low(phase_d);
        sda_oe_d = (cmd_d == CMD_READ) ? ~nack_d : 1'b0;
      end
      ST_STOP: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d == 2'd0) || (phase_d == 2'd1);
      end
      ST_DONE: begin
        scl_oe_d = (cmd_d != CMD_STOP);
        sda_oe_d = sda_oe_q;
      end
      default: begin
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      cmd_q       <= CMD_START;
      nack_q      <= 1'b0;
      rd_data_q   <= 8'h00;
      ack_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      nack_q      <= nack_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rd_data      = rd_data_q;
  assign ack_received = ack_q;
  assign busy         = busy_q;
  assign scl_oe       = scl_oe_q;
  assign sda_oe       = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with CLK_DIV=3 (Q=4): open-drain
// pull-up model plus a simple target that ACKs, NACKs, sends data and stretches.
module tb_i2c_byte_master;
  import i2c_pkg::*;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       rd_nack;
  logic       rsp_valid;
  logic [7:0] rd_data;
  logic       ack_received;
  logic       busy;
  logic       scl_oe, sda_oe;
  logic       scl_line, sda_line;

  logic       tgt_sda_low;
  logic       tgt_stretch;
  logic [8:0] tgt_pat;
  int         tgt_slot;
  logic       stretch_arm;
  int         stretch_cnt;

  logic [8:0] samp;
  logic       scl_prev, sda_prev;
  int         cyc, acc_cyc, sda_rise_cyc, scl_fall_cyc;
  int         n_chk, n_pass;

  assign scl_line = ~scl_oe & ~tgt_stretch;
  assign sda_line = ~sda_oe & ~tgt_sda_low;

  i2c_byte_master #(.CLK_DIV(3)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd          (cmd),
    .wr_data      (wr_data),
    .rd_nack      (rd_nack),
    .rsp_valid    (rsp_valid),
    .rd_data      (rd_data),
    .ack_received (ack_received),
    .busy         (busy),
    .scl_i        (scl_line),
    .sda_i        (sda_line),
    .scl_oe       (scl_oe),
    .sda_oe       (sda_oe)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic pat_low(input logic [8:0] pat, input int slot);
    if (slot >= 0 && slot <= 8) return pat[8-slot];
    else return 1'b0;
  endfunction

  // One cycle: advance to the negedge, then update the target and observers.
  task automatic step();
    @(negedge sys_clk);
    cyc++;
    if (!scl_prev && scl_oe) begin
      tgt_slot++;
      if (scl_fall_cyc < 0) scl_fall_cyc = cyc;
    end
    if (scl_prev && !scl_oe) samp = {samp[7:0], sda_line};
    if (!sda_prev && sda_oe && sda_rise_cyc < 0) sda_rise_cyc = cyc;
    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) tgt_stretch = 1'b0;
    end else if (stretch_arm && tgt_slot == 3 && !scl_oe) begin
      tgt_stretch = 1'b1;
      stretch_cnt = 20;
      stretch_arm = 1'b0;
    end
    tgt_sda_low = pat_low(tgt_pat, tgt_slot);
    scl_prev = scl_oe;
    sda_prev = sda_oe;
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk, input logic [8:0] pat);
    int n = 0;
    while (!cmd_ready && n < 400) begin step(); n++; end
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    cmd = c; wr_data = d; rd_nack = nk; cmd_valid = 1'b1;
    tgt_pat = pat; tgt_slot = 0; tgt_sda_low = pat_low(pat, 0);
    sda_rise_cyc = -1; scl_fall_cyc = -1;
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n = 0;
    while (!rsp_valid && n < 400) begin step(); n++; end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk,
                         input logic [8:0] pat, output int lat);
    issue(c, d, nk, pat);
    wait_rsp(lat);
  endtask

  initial begin
    int lat, n, cnt, rsp1, rsp2, acc2, acc_n;
    logic drop;
    n_chk = 0; n_pass = 0; cyc = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd = CMD_START; wr_data = 8'h00; rd_nack = 1'b0;
    tgt_sda_low = 1'b0; tgt_stretch = 1'b0; tgt_pat = 9'h000; tgt_slot = 0;
    stretch_arm = 1'b0; stretch_cnt = 0; samp = 9'h000;
    scl_prev = 1'b0; sda_prev = 1'b0; sda_rise_cyc = -1; scl_fall_cyc = -1;

    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 32'd1);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ack", ack_received, 32'd0);
    check("rst_scl_oe", scl_oe, 32'd0);
    check("rst_sda_oe", sda_oe, 32'd0);
    check("rst_rd_data", rd_data, 32'h00);
    reset = 1'b0;
    step();

    // START from bus idle: SDA falls at q2, SCL at q3, done at 3Q+1
    run_cmd(CMD_START, 8'h00, 1'b0, 9'h000, lat);
    check("start_lat", lat, 32'd13);
    check("start_sda_first", sda_rise_cyc - acc_cyc, 32'd5);
    check("start_scl_after", scl_fall_cyc - acc_cyc, 32'd9);
    step();
    check("start_scl_held", scl_oe, 32'd1);

    run_cmd(CMD_WRITE, 8'hA5, 1'b0, 9'h001, lat);
    check("wr_a5_lat", lat, 32'd145);
    check("wr_a5_data", samp[8:1], 32'hA5);
    check("wr_a5_ack", ack_received, 32'd1);

    run_cmd(CMD_WRITE, 8'h3C, 1'b0, 9'h000, lat);
    check("wr_3c_lat", lat, 32'd145);
    check("wr_3c_data", samp[8:1], 32'h3C);
    check("wr_3c_nack", ack_received, 32'd0);

    // Target sends 0xC3: it pulls low where the bit is 0 (~C3 = 3C), releases ACK slot
    run_cmd(CMD_READ, 8'h00, 1'b1, {8'h3C, 1'b0}, lat);
    check("rd_lat", lat, 32'd145);
    check("rd_data", rd_data, 32'hC3);
    check("rd_nack_released", samp[0], 32'd1);
    check("rd_ack_held", ack_received, 32'd0);

    run_cmd(CMD_START, 8'h00, 1'b0, 9'h000, lat);
    check("rstart_lat", lat, 32'd17);

    run_cmd(CMD_STOP, 8'h00, 1'b0, 9'h000, lat);
    check("stop_lat", lat, 32'd17);
    step();
    check("stop_scl_rel", scl_oe, 32'd0);
    check("stop_sda_rel", sda_oe, 32'd0);

    // Clock stretch of 20 cycles in bit 3
    run_cmd(CMD_START, 8'h00, 1'b0, 9'h000, lat);
    check("start2_lat", lat, 32'd13);
    stretch_arm = 1'b1;
    run_cmd(CMD_WRITE, 8'h5A, 1'b0, 9'h001, lat);
    check("stretch_lat", lat, 32'd165);
    check("stretch_data", samp[8:1], 32'h5A);
    check("stretch_ack", ack_received, 32'd1);

    // Reset in the middle of bit 5 of a WRITE
    issue(CMD_WRITE, 8'h81, 1'b0, 9'h001);
    n = 0;
    while (tgt_slot != 5 && n < 400) begin step(); n++; end
    check("rst_reach_bit5", tgt_slot, 32'd5);
    reset = 1'b1;
    step();
    check("midrst_scl_oe", scl_oe, 32'd0);
    check("midrst_sda_oe", sda_oe, 32'd0);
    check("midrst_ready", cmd_ready, 32'd1);
    check("midrst_rsp", rsp_valid, 32'd0);
    reset = 1'b0;
    tgt_pat = 9'h000; tgt_sda_low = 1'b0;
    cnt = 0;
    repeat (200) begin step(); if (rsp_valid) cnt++; end
    check("midrst_no_rsp", cnt, 32'd0);
    run_cmd(CMD_START, 8'h00, 1'b0, 9'h000, lat);
    check("post_rst_start_lat", lat, 32'd13);

    // cmd_valid held across a busy command: second one accepted once, right after rsp
    n = 0;
    while (!cmd_ready && n < 400) begin step(); n++; end
    cmd = CMD_START; cmd_valid = 1'b1; tgt_pat = 9'h000; acc_cyc = cyc;
    step();
    cmd = CMD_STOP;
    rsp1 = -1; rsp2 = -1; acc2 = -1; acc_n = 0; drop = 1'b0; n = 0;
    while (rsp2 < 0 && n < 600) begin
      step(); n++;
      if (drop) begin cmd_valid = 1'b0; drop = 1'b0; end
      if (rsp_valid) begin
        if (rsp1 < 0) rsp1 = cyc;
        else rsp2 = cyc;
      end
      if (cmd_valid && cmd_ready) begin acc_n++; acc2 = cyc; drop = 1'b1; end
    end
    cmd_valid = 1'b0;
    check("b2b_first_lat", rsp1 - acc_cyc, 32'd17);
    check("b2b_accept_after_rsp", acc2 - rsp1, 32'd1);
    check("b2b_accept_once", acc_n, 32'd1);
    check("b2b_second_lat", rsp2 - acc2, 32'd17);
    cnt = 0;
    repeat (100) begin step(); if (rsp_valid) cnt++; end
    check("b2b_no_extra_rsp", cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
